// File: rtl/expr_sig_compactor.sv
// Response compactor: folds each accepted result word into a MISR and compares against a golden signature.
// Optional watchdog built when EXPR_SIG_TIMEOUT_EN is defined; otherwise timeout is tied low.
//
// state  | meaning
// S_IDLE | after reset, waiting for start
// S_RUN  | accepting result words, in_ready high
// S_DONE | run finished, signature/pass/timeout hold until next start
module expr_sig_compactor #(
    parameter int               Y_W     = 90,
    parameter int               SIG_W   = 32,
    parameter int               CNT_W   = 16,
    parameter logic [SIG_W-1:0] POLY    = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] SEED    = 32'hFFFFFFFF,
    parameter int               TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [SIG_W-1:0] expect_sig,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Y_W-1:0]   in_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] vec_count
);

    localparam int NCH = (Y_W + SIG_W - 1) / SIG_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SIG_W-1:0]     sig_q, sig_d;
    logic [SIG_W-1:0]     exp_q, exp_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     num_q, num_d;
    logic                 pass_q, pass_d;
    logic [SIG_W-1:0]     fold;
    logic [SIG_W-1:0]     sig_next;
    logic [NCH*SIG_W-1:0] y_pad;
    logic                 accept;
    logic                 last_word;
    logic                 start_take;
    logic                 wd_expire;

    // Top chunk is zero-extended by padding the word up to a whole number of chunks.
    always_comb begin
        y_pad = '0;
        y_pad[Y_W-1:0] = in_y;
        fold = '0;
        for (int i = 0; i < NCH; i++) begin
            fold = fold ^ y_pad[i*SIG_W +: SIG_W];
        end
    end

    assign sig_next   = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold;
    assign accept     = in_valid && (state_q == S_RUN);
    assign last_word  = (cnt_q + CNT_W'(1)) == num_q;
    assign start_take = start && (state_q != S_RUN);

`ifdef EXPR_SIG_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_q, to_d;

    // Down-counter reloads on every accept; reaching zero on an idle RUN cycle aborts the run.
    assign wd_expire = (state_q == S_RUN) && !accept && (wd_q == '0);

    always_comb begin
        wd_d = wd_q;
        to_d = to_q;
        if (start_take) begin
            wd_d = WD_LOAD;
            to_d = 1'b0;
        end else if (state_q == S_RUN) begin
            if (accept) begin
                wd_d = WD_LOAD;
            end else if (wd_q == '0) begin
                to_d = 1'b1;
            end else begin
                wd_d = wd_q - WD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q <= WD_LOAD;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    assign timeout = to_q;
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    sig_d  = SEED;
                    cnt_d  = '0;
                    num_d  = num_vec;
                    exp_d  = expect_sig;
                    pass_d = 1'b0;
                    if (num_vec == '0) begin
                        // Empty run: the final signature is the seed itself.
                        state_d = S_DONE;
                        pass_d  = (SEED == expect_sig);
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    sig_d = sig_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_word) begin
                        state_d = S_DONE;
                        pass_d  = (sig_next == exp_q);
                    end
                end else if (wd_expire) begin
                    state_d = S_DONE;
                    pass_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sig_q   <= SEED;
            exp_q   <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            pass_q  <= pass_d;
        end
    end

    assign in_ready  = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign signature = sig_q;
    assign vec_count = cnt_q;

endmodule

// File: tb/tb_expr_sig_compactor.sv
// Scoreboard bench for expr_sig_compactor: expected signatures are computed from an
// independent MISR model when a run is launched and popped when the run reaches DONE.
module tb_expr_sig_compactor;

    localparam logic [31:0] SEED = 32'hFFFFFFFF;
    localparam logic [31:0] POLY = 32'h04C11DB7;

    typedef logic [89:0] y_t;
    typedef struct {
        logic [31:0] sig;
        logic        pass;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] num_vec;
    logic [31:0] expect_sig;
    logic        in_valid;
    logic        in_ready;
    y_t          in_y;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [31:0] signature;
    logic [15:0] vec_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    expr_sig_compactor #(
        .Y_W(90), .SIG_W(32), .CNT_W(16), .POLY(POLY), .SEED(SEED), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_vec(num_vec),
        .expect_sig(expect_sig), .in_valid(in_valid), .in_ready(in_ready),
        .in_y(in_y), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .signature(signature), .vec_count(vec_count)
    );

    function automatic logic [31:0] misr_step(input logic [31:0] s, input y_t y);
        logic [31:0] f;
        f = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
    endfunction

    function automatic y_t rand_y();
        return {$urandom(), $urandom(), 26'($urandom())};
    endfunction

    // All tasks start and end on a falling edge.
    task automatic drive_start(input logic [15:0] n, input logic [31:0] e);
        start = 1'b1; num_vec = n; expect_sig = e;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input y_t ys[$], input int gap_max);
        foreach (ys[i]) begin
            int gap;
            int guard;
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            guard = 0;
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
            in_valid = 1'b1;
            in_y = ys[i];
            while (in_ready !== 1'b1 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) begin
                n_checks++; n_fail++;
                $display("FAIL feed_ready word %0d: in_ready never rose (got %b, want 1)", i, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_check(input string name, input y_t ys[$], input logic [31:0] exp_sig,
                             input int gap_max);
        logic [31:0] s;
        exp_t e;
        s = SEED;
        foreach (ys[i]) s = misr_step(s, ys[i]);
        e.sig = s; e.pass = (s == exp_sig); e.cnt = 16'(ys.size());
        sb.push_back(e);
        drive_start(16'(ys.size()), exp_sig);
        feed(ys, gap_max);
        e = sb.pop_front();
        n_checks++;
        if (done !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done/in_ready: got %b/%b want 1/0", name, done, in_ready);
        end
        n_checks++;
        if (signature !== e.sig) begin
            n_fail++;
            $display("FAIL %s signature: got %h want %h", name, signature, e.sig);
        end
        n_checks++;
        if (pass !== e.pass) begin
            n_fail++;
            $display("FAIL %s pass: got %b want %b", name, pass, e.pass);
        end
        n_checks++;
        if (vec_count !== e.cnt || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL %s vec_count/timeout: got %0d/%b want %0d/0", name, vec_count, timeout, e.cnt);
        end
    endtask

    task automatic check_reset_vals(input string name);
        n_checks++;
        if ({in_ready, busy, done, pass, timeout} !== 5'b0 || signature !== SEED || vec_count !== 16'd0) begin
            n_fail++;
            $display("FAIL %s: got rdy=%b busy=%b done=%b pass=%b to=%b sig=%h cnt=%0d want 0 0 0 0 0 %h 0",
                     name, in_ready, busy, done, pass, timeout, signature, vec_count, SEED);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; num_vec = '0; expect_sig = '0; in_valid = 1'b0; in_y = '0;
        #2;
        check_reset_vals("reset_async");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("reset_release");
    endtask

    task automatic test_single_zero();
        y_t ys[$];
        ys = '{90'h0};
        run_check("single_zero", ys, 32'hFB3EE249, 0);
        n_checks++;
        if (signature !== 32'hFB3EE249 || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL single_zero_const: got %h/%b want fb3ee249/1", signature, pass);
        end
    endtask

    task automatic test_fold();
        y_t ys[$];
        y_t y;
        y = '0; y[32] = 1'b1; ys = '{y};
        run_check("fold_bit32", ys, 32'h0, 0);
        n_checks++;
        if (signature !== 32'hFB3EE248) begin
            n_fail++;
            $display("FAIL fold_bit32_const: got %h want fb3ee248", signature);
        end
        y = '0; y[64] = 1'b1; y[89] = 1'b1; ys = '{y};
        run_check("fold_top", ys, misr_step(SEED, y), 1);
    endtask

    task automatic test_back_to_back();
        y_t ys[$];
        logic [31:0] s;
        ys = '{90'h1, 90'h0};
        run_check("b2b", ys, 32'h0, 0);
        s = misr_step(misr_step(SEED, 90'h1), 90'h0);
        in_valid = 1'b1; in_y = rand_y();
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (vec_count !== 16'd2 || signature !== s || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_extra_word: got cnt=%0d sig=%h rdy=%b want 2 %h 0", vec_count, signature, in_ready, s);
        end
    endtask

    task automatic test_zero_vec();
        drive_start(16'd0, ~SEED);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || signature !== SEED || vec_count !== 16'd0 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_vec: got done=%b busy=%b sig=%h cnt=%0d pass=%b want 1 0 %h 0 0",
                     done, busy, signature, vec_count, pass, SEED);
        end
        in_valid = 1'b1; in_y = rand_y();
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (vec_count !== 16'd0 || signature !== SEED) begin
            n_fail++;
            $display("FAIL zero_vec_no_accept: got cnt=%0d sig=%h want 0 %h", vec_count, signature, SEED);
        end
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 4; r++) begin
            y_t ys[$];
            logic [31:0] s;
            int n;
            n = int'($urandom_range(6, 1));
            ys = {};
            s = SEED;
            for (int k = 0; k < n; k++) begin
                ys.push_back(rand_y());
                s = misr_step(s, ys[k]);
            end
            run_check($sformatf("random_%0d", r), ys, (r % 2 == 0) ? s : (s ^ 32'h8000_0000), 2);
        end
    endtask

    task automatic test_start_with_valid();
        y_t y;
        y = rand_y();
        start = 1'b1; num_vec = 16'd1; expect_sig = misr_step(SEED, y);
        in_valid = 1'b1; in_y = y;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || vec_count !== 16'd0 || signature !== SEED) begin
            n_fail++;
            $display("FAIL start_wins: got busy=%b cnt=%0d sig=%h want 1 0 %h", busy, vec_count, signature, SEED);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (done !== 1'b1 || signature !== misr_step(SEED, y) || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL start_wins_accept: got done=%b sig=%h pass=%b want 1 %h 1",
                     done, signature, pass, misr_step(SEED, y));
        end
    endtask

    task automatic test_reset_midrun();
        y_t ys[$];
        y_t first[$];
        for (int k = 0; k < 10; k++) ys.push_back(rand_y());
        first = ys[0:4];
        drive_start(16'd10, 32'h0);
        feed(first, 1);
        drive_start(16'd1, 32'h0);
        n_checks++;
        if (busy !== 1'b1 || vec_count !== 16'd5) begin
            n_fail++;
            $display("FAIL start_ignored_in_run: got busy=%b cnt=%0d want 1 5", busy, vec_count);
        end
        #2 reset = 1'b1;
        #1 check_reset_vals("reset_midrun");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        begin
            logic [31:0] s;
            s = SEED;
            foreach (ys[i]) s = misr_step(s, ys[i]);
            run_check("rerun_after_reset", ys, s, 1);
        end
    endtask

    task automatic test_timeout();
        int busy_cycles;
        busy_cycles = 0;
        drive_start(16'd3, 32'h0);
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) break;
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
        end
`ifdef EXPR_SIG_TIMEOUT_EN
        n_checks++;
        if (busy_cycles != 8 || done !== 1'b1 || timeout !== 1'b1 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_fire: got run_cycles=%0d done=%b to=%b pass=%b want 8 1 1 0",
                     busy_cycles, done, timeout, pass);
        end
`else
        n_checks++;
        if (busy_cycles != 40 || busy !== 1'b1 || done !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL no_watchdog: got run_cycles=%0d busy=%b done=%b to=%b want 40 1 0 0",
                     busy_cycles, busy, done, timeout);
        end
`endif
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("reset_after_timeout");
    endtask

    initial begin
        test_reset();
        test_single_zero();
        test_fold();
        test_back_to_back();
        test_zero_vec();
        test_random_runs();
        test_start_with_valid();
        test_reset_midrun();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation still running at %0t, want finished", $time);
        $fatal(1, "time limit");
    end

endmodule
